ram8_clear: RTL
===============

# ram8_clear

Eight-word register memory with a hardware block-clear sequencer. It sits directly downstream of the `DMux8Way` decoder: `load` is routed through a `DMux8Way` instance (`sel` = `address`) to produce the eight per-register load enables. Read data is selected back out by `address`. The clear sequencer lets software zero the whole memory in a fixed 8-cycle sweep without asserting system reset.

## Interface

Parameters:
- `WIDTH`, default 16: word width of every register and of `in` / `out`.

Ports:
- `clk`  input  1  — single clock; all state updates on the rising edge.
- `reset`  input  1  — synchronous, active-high reset.
- `in`  input  WIDTH  — write data.
- `load`  input  1  — write enable; writes `in` to register[`address`] at the edge.
- `address`  input  3  — selects the register for both write and read.
- `clear`  input  1  — sweep request; sampled only in IDLE or DONE.
- `out`  output  WIDTH  — combinational read of register[`address`].
- `busy`  output  1  — high while the sweep is in progress.
- `done`  output  1  — one-cycle pulse when the sweep completes.

## Operation

- Storage is eight registers r0..r7. Write decode is a `DMux8Way` instance: `in` = `load & ~busy`, `sel` = `address`, outputs a..h drive the load enables of r0..r7.
- Read: `out` = r[`address`], purely combinational. No read latency.
- FSM states and transitions:
  - IDLE: `clear` = 1 → SWEEP, counter `cnt` ← 0. Otherwise stay in IDLE.
  - SWEEP: each edge writes 0 to r[`cnt`] and increments `cnt`. When `cnt` = 7, the final write is performed and the FSM moves to DONE.
  - DONE: lasts one cycle, then → IDLE. If `clear` = 1 in DONE, the FSM goes → SWEEP instead (back-to-back sweep), with `cnt` ← 0.
- `busy` = (state == SWEEP). `done` = (state == DONE). Both are decoded from registered state, so they are glitch-free.
- External `load` is honoured in IDLE and DONE.
- External `load` in SWEEP is dropped. It is not queued or deferred.
- `clear` in SWEEP is ignored. The sweep is not restarted or extended.
- `load` and `clear` in the same IDLE cycle: the write is performed at that edge, then the sweep starts. The sweep later zeroes the written word.
- `cnt` is 3 bits and never wraps mid-sweep. The exit is at `cnt` = 7.
- Reset values:
  - all registers r0..r7 = 0, so `out` = 0 for every address;
  - `busy` = 0, `done` = 0;
  - state = IDLE, `cnt` = 0.
- Reset takes priority over `load` and `clear` in the same cycle.
- Reset mid-sweep aborts the sweep: state goes to IDLE, all registers are zeroed, and `done` never pulses for the aborted sweep.

## Timing

- Write latency: a `load` sampled at edge E is visible on `out` immediately after E, provided `address` is unchanged.
- Sweep, with `clear` sampled high at edge E0:
  - after E0: state = SWEEP, `busy` = 1;
  - edge E(k+1) zeroes r_k, for k = 0..7;
  - after E8: `busy` = 0, `done` = 1;
  - after E9: `done` = 0, state = IDLE.
- `busy` is high for exactly 8 cycles. `done` is high for exactly 1 cycle.
- External writes are blocked from E1 through E8 inclusive.
- The earliest accepted external write after a sweep is at edge E9, in the DONE cycle.

## Test plan

- Reset: hold `reset` = 1 for one edge with `load` = 1, `in` = 0xFFFF, `address` = 3. → Reads of addresses 0..7 all return 0x0000; `busy` = 0, `done` = 0.
- Write/readback: write 0x1111·i to address i for i = 0..7. → Reading address i returns 0x1111·i. Then toggle `in` with `load` = 0. → All contents are unchanged.
- Full sweep: fill every address with 0xABCD, then pulse `clear` for one cycle.
  - `busy` is high for exactly 8 cycles, then `done` is high for 1 cycle.
  - After E4: r0..r3 = 0x0000 and r4..r7 = 0xABCD.
  - After E8: all registers = 0x0000.
- Blocked writes during sweep: in the cycle after E2, apply `load` = 1, `address` = 7, `in` = 0x5555, and re-assert `clear`. → r7 = 0x0000 after the sweep; `done` still occurs after E8 with no extension; no second sweep starts.
- Simultaneous load and clear in IDLE: `address` = 2, `in` = 0x1234, `load` = `clear` = 1. → r2 reads 0x1234 after E0 and 0x0000 after E3.
- Reset mid-sweep:
  - Fill with 0xBEEF, start a sweep, assert `reset` at E4. → After E4: `busy` = 0, `done` = 0, all reads 0x0000.
  - `done` stays 0 for the next 10 cycles.
  - A write issued at E5 is accepted.

Source files
------------

// File: rtl/ram8_clear.sv
// Eight-word register memory with a one-cycle-per-word block-clear sweep.
// Write enables come from a dmux8way decoder that is held off while the sweep runs.

module dmux8way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h
);

  assign a = in & (sel == 3'd0);
  assign b = in & (sel == 3'd1);
  assign c = in & (sel == 3'd2);
  assign d = in & (sel == 3'd3);
  assign e = in & (sel == 3'd4);
  assign f = in & (sel == 3'd5);
  assign g = in & (sel == 3'd6);
  assign h = in & (sel == 3'd7);

endmodule

module ram8_clear #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [8];
  logic [7:0]       wr_en;

  // External writes are dropped, not deferred, while the sweep owns the array.
  dmux8way u_dmux (
    .in  (load & ~busy),
    .sel (address),
    .a   (wr_en[0]),
    .b   (wr_en[1]),
    .c   (wr_en[2]),
    .d   (wr_en[3]),
    .e   (wr_en[4]),
    .f   (wr_en[5]),
    .g   (wr_en[6]),
    .h   (wr_en[7])
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          state_d = StSweep;
          cnt_d   = 3'd0;
        end
      end
      StSweep: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = StDone;
      end
      StDone: begin
        if (clear) begin
          state_d = StSweep;
          cnt_d   = 3'd0;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == StSweep);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_en[i]) begin
          mem_q[i] <= in;
        end else if (busy && (cnt_q == 3'(i))) begin
          mem_q[i] <= '0;
        end
      end
    end
  end

  assign out = mem_q[address];

endmodule
